// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the serial wide adder.
// State encoding and index-width helper used by serial_wide_adder_ctrl.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Never return 0 so idx is always at least one bit wide.
    function automatic int idx_width(input int words);
        return (words <= 2) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/add_slice.sv
// N-bit combinational ripple-carry adder slice built from a chain of full adders.
module add_slice #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    logic [N:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[N];

endmodule

// File: rtl/serial_wide_adder_ctrl.sv
// Serial N*WORDS-bit adder time-sharing one N-bit slice, LS word first.
// Optional subtract mode compiled in with SERIAL_ADD_SUB_EN.
module serial_wide_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic                 sub_in,
`endif
    input  logic [N*WORDS-1:0]   a_in,
    input  logic [N*WORDS-1:0]   b_in,
    input  logic                 carry_in,
    output logic                 busy,
    output logic                 done,
    output logic [N*WORDS-1:0]   sum_out,
    output logic                 carry_out
);

    localparam int W  = N * WORDS;
    localparam int IW = idx_width(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    state_t          state;
    state_t          next_state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            carry_q;
    logic [IW-1:0]   idx;
    logic [N-1:0]    a_word;
    logic [N-1:0]    b_word;
    logic [N-1:0]    s_word;
    logic            c_word;
    logic            accept;
    logic            last;
    logic [W-1:0]    b_eff;
    logic            cin_eff;

`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: invert B and inject a carry of one.
    assign b_eff   = sub_in ? ~b_in : b_in;
    assign cin_eff = sub_in ? 1'b1 : carry_in;
`else
    assign b_eff   = b_in;
    assign cin_eff = carry_in;
`endif

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign last   = (idx == LAST_IDX);
    assign a_word = a_reg[idx*N +: N];
    assign b_word = b_reg[idx*N +: N];

    add_slice #(.N(N)) u_slice (
        .a  (a_word),
        .b  (b_word),
        .ci (carry_q),
        .s  (s_word),
        .co (c_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = start ? RUN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_q   <= 1'b0;
            idx       <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            a_reg   <= a_in;
            b_reg   <= b_eff;
            carry_q <= cin_eff;
            idx     <= '0;
        end else if (state == RUN) begin
            sum_out[idx*N +: N] <= s_word;
            carry_q             <= c_word;
            if (last) begin
                carry_out <= c_word;
                idx       <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_wide_adder_ctrl.sv
// Self-checking bench for serial_wide_adder_ctrl (N=4, WORDS=4); covers subtract mode when SERIAL_ADD_SUB_EN is defined.
module tb_serial_wide_adder_ctrl;

    localparam int N     = 4;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         carry_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         carry_out;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub_in = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_wide_adder_ctrl #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef SERIAL_ADD_SUB_EN
        .sub_in    (sub_in),
`endif
        .a_in      (a_in),
        .b_in      (b_in),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum_out   (sum_out),
        .carry_out (carry_out)
    );

    // Reference: plain W+1-bit addition.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Drives one op at negedges; lat = cycle index (start cycle's successor = 1) where done is first seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output logic [W-1:0] s, output logic co, output int lat, output int bcnt);
        int cyc;
        @(negedge clk);
        a_in = a; b_in = b; carry_in = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom); carry_in = 1'($urandom);
        cyc  = 1;
        bcnt = 0;
        while (!done && cyc < 20) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        lat = cyc;
        s   = sum_out;
        co  = carry_out;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, sum_out, carry_out} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b, required all zero", busy, done, sum_out, carry_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [3] = '{16'h1234, 16'hFFFF, 16'hFFFF};
        logic [W-1:0] vb [3] = '{16'h1111, 16'h0001, 16'hFFFF};
        logic         vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [W:0]   req [3] = '{17'h0_2345, 17'h1_0000, 17'h1_FFFF};
        logic [W-1:0] s;
        logic         co;
        int           lat, bcnt;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vc[i], s, co, lat, bcnt);
            n_checks++;
            if (lat !== WORDS + 1) begin
                n_fail++;
                $display("FAIL latency_%0d: got %0d, required %0d", i, lat, WORDS + 1);
            end
            n_checks++;
            if (bcnt !== WORDS) begin
                n_fail++;
                $display("FAIL busy_len_%0d: got %0d, required %0d", i, bcnt, WORDS);
            end
            n_checks++;
            if ({co, s} !== req[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: got %h, required %h", i, {co, s}, req[i]);
            end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || {carry_out, sum_out} !== req[i]) begin
                n_fail++;
                $display("FAIL hold_%0d: done=%b result=%h, required done=0 result=%h", i, done, {carry_out, sum_out}, req[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, s;
        logic         c, co;
        logic [W:0]   req;
        int           lat, bcnt;
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            if (i == 0) begin a = '1; b = '0; c = 1'b1; end
            req = ref_add(a, b, c);
            run_op(a, b, c, s, co, lat, bcnt);
            n_checks++;
            if ({co, s} !== req || lat !== WORDS + 1) begin
                n_fail++;
                $display("FAIL random_%0d: a=%h b=%h c=%b got %h lat=%0d, required %h lat=%0d",
                         i, a, b, c, {co, s}, lat, req, WORDS + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2;
        logic [W:0]   req1, req2;
        int           cyc;
        a1 = W'($urandom); b1 = W'($urandom);
        a2 = W'($urandom); b2 = W'($urandom);
        req1 = ref_add(a1, b1, 1'b0);
        req2 = ref_add(a2, b2, 1'b1);
        @(negedge clk);
        a_in = a1; b_in = b1; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        cyc = 1;
        // Keep start high with different operands for three RUN cycles.
        a_in = ~a1; b_in = ~b1; carry_in = 1'b1;
        while (!done && cyc < 20) begin
            if (cyc > 3) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if ({carry_out, sum_out} !== req1 || cyc !== WORDS + 1) begin
            n_fail++;
            $display("FAIL ignore_start: got %h at cycle %0d, required %h at cycle %0d",
                     {carry_out, sum_out}, cyc, req1, WORDS + 1);
        end
        a_in = a2; b_in = b2; carry_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if ({carry_out, sum_out} !== req2 || cyc !== WORDS + 1) begin
            n_fail++;
            $display("FAIL back_to_back: got %h at cycle %0d, required %h at cycle %0d",
                     {carry_out, sum_out}, cyc, req2, WORDS + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic saw_done;
        @(negedge clk);
        a_in = 16'hFFFF; b_in = 16'h0001; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy, done, sum_out, carry_out} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_state: busy=%b done=%b sum=%h cout=%b, required all zero", busy, done, sum_out, carry_out);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_quiet: activity seen=%b, required 0", saw_done);
        end
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        logic [W-1:0] s, a, b;
        logic         co;
        logic [W:0]   req;
        int           lat, bcnt;
        sub_in = 1'b1;
        run_op(16'h0005, 16'h0007, 1'b0, s, co, lat, bcnt);
        n_checks++;
        if ({co, s} !== 17'h0_FFFE) begin
            n_fail++;
            $display("FAIL sub_borrow: got %h, required %h", {co, s}, 17'h0_FFFE);
        end
        run_op(16'h0007, 16'h0005, 1'b0, s, co, lat, bcnt);
        n_checks++;
        if ({co, s} !== 17'h1_0002) begin
            n_fail++;
            $display("FAIL sub_noborrow: got %h, required %h", {co, s}, 17'h1_0002);
        end
        for (int i = 0; i < 8; i++) begin
            a = W'($urandom); b = W'($urandom);
            req = {(a >= b), W'(a - b)};
            run_op(a, b, 1'($urandom), s, co, lat, bcnt);
            n_checks++;
            if ({co, s} !== req) begin
                n_fail++;
                $display("FAIL sub_random_%0d: a=%h b=%h got %h, required %h", i, a, b, {co, s}, req);
            end
        end
        sub_in = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_mid_reset();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
